conv_window_sequencer: RTL and testbench
========================================

Name: conv_window_sequencer

Overview:
- Frame-level controller for the Layer_5 convolution datapath. Accepts a raster pixel stream of one IMG_WIDTH x IMG_HEIGHT frame with a valid/ready handshake.
- Drives the line-buffer and window-shift enables, and tracks the column and row positions.
- Flags each pixel that completes a full KERNEL x KERNEL window and presents it through a one-deep output slot with backpressure.
- Sits between the input feature-map reader and the MAC array, and replaces free-running per-layer column counters.

Parameters:
- IMG_WIDTH, 100, pixels per row.
- IMG_HEIGHT, 100, rows per frame.
- KERNEL, 3, square kernel size; 1 < KERNEL <= IMG_WIDTH and KERNEL <= IMG_HEIGHT.
- CNT_WIDTH, 14, width of the column, row and output counters; must hold IMG_WIDTH*IMG_HEIGHT.

Ports:
- Clk  input  1  clock, rising edge.
- Rst  input  1  asynchronous, active-low reset.
- Start  input  1  begin a frame; sampled only in IDLE.
- In_Valid  input  1  upstream pixel available.
- In_Ready  output  1  sequencer accepts a pixel this cycle.
- Out_Ready  input  1  MAC array consumes the window.
- Out_Valid  output  1  a complete window is present.
- Shift_En  output  1  shift the window registers and write the line buffers; equals In_Valid & In_Ready.
- Row_Start  output  1  the accepted pixel is column 1 of a row.
- Col_Idx  output  CNT_WIDTH  1-based column of the last accepted pixel.
- Row_Idx  output  CNT_WIDTH  1-based row of the last accepted pixel.
- Out_Count  output  CNT_WIDTH  windows handed off this frame.
- Busy  output  1  state is not IDLE.
- Done  output  1  one-cycle pulse at end of frame.

Behaviour:
- Reset (Rst low, asynchronous):
  - State is IDLE.
  - Col_Idx, Row_Idx and Out_Count are 0.
  - Out_Valid, Done and Busy are 0.
  - Reset mid-frame aborts immediately; no Done pulse is produced.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - In_Ready = 0.
  - On Start = 1, go to RUN and clear Col_Idx, Row_Idx and Out_Count to 0 on that edge.
- RUN:
  - In_Ready = !Out_Valid | Out_Ready.
  - Accept = In_Valid & In_Ready; Shift_En = Accept (combinational).
  - Row_Start = Accept & (Col_Idx == IMG_WIDTH | Col_Idx == 0).
- Counters on Accept:
  - Col_Idx wraps IMG_WIDTH -> 1; otherwise it increments (0 -> 1 on the first pixel).
  - Row_Idx increments when Col_Idx wraps or on the first pixel (0 -> 1).
  - Both counters hold when there is no Accept.
- Window completion:
  - The accepted pixel at next column c and next row r completes a window when c >= KERNEL and r >= KERNEL.
  - On that edge Out_Valid is set to 1 (registered, 1-cycle latency).
- Output slot:
  - Out_Valid holds until Out_Ready = 1.
  - If Out_Ready = 1 and a new completing Accept occur in the same cycle, Out_Valid stays 1 and Out_Count increments by 1.
  - If Out_Ready = 1 without a new completion, Out_Valid clears.
  - Out_Count increments on every Out_Valid & Out_Ready, saturating at 2^CNT_WIDTH-1.
- Last pixel: the Accept at column IMG_WIDTH, row IMG_HEIGHT moves the state to DRAIN. That pixel always completes a window, so Out_Valid = 1.
- DRAIN:
  - In_Ready = 0.
  - When Out_Valid & Out_Ready, go to DONE.
- DONE:
  - Done = 1 for exactly one cycle, then return to IDLE.
  - Out_Count is held at (IMG_WIDTH-KERNEL+1)*(IMG_HEIGHT-KERNEL+1), which is 9604 at the defaults.
- Start asserted outside IDLE is ignored.
- In_Valid while in IDLE, DRAIN or DONE is not accepted, and the counters do not move.
- Busy = 1 in RUN, DRAIN and DONE.
- Widths: all comparisons are unsigned at CNT_WIDTH bits; no counter exceeds its limit except Out_Count saturation, which is a debug guard only.

Test Plan:
- Reset then idle:
  - Stimulus: hold Rst low 3 cycles, release, drive In_Valid = 1 with Start = 0 for 10 cycles.
  - Required: In_Ready = 0, counters stay 0, Busy = 0, no Shift_En.
- Full frame, no stalls:
  - Stimulus: Start, In_Valid = 1 and Out_Ready = 1 continuously.
  - Required: 10000 Shift_En pulses; 100 Row_Start pulses; first Out_Valid on the cycle after pixel (col 3, row 3), i.e. the 203rd accept; 98 windows per row for rows 3..100; Done exactly once; Out_Count = 9604.
- Backpressure:
  - Stimulus: Out_Ready = 0 for 5 cycles starting while Out_Valid = 1.
  - Required: In_Ready = 0 during the stall; Out_Valid stays 1; Col_Idx and Row_Idx frozen; no pixel lost; final Out_Count still 9604.
- Row wrap:
  - Stimulus: Accept at Col_Idx = 100.
  - Required: next Col_Idx = 1, Row_Idx +1, Row_Start = 1; no Out_Valid from pixels at col 1 or 2.
- Drain and Start during frame:
  - Stimulus: assert Start mid-RUN; hold Out_Ready = 0 after the last pixel for 4 cycles.
  - Required: Start ignored; state stays DRAIN with In_Ready = 0; Done occurs 1 cycle after Out_Ready rises.
- Async reset mid-frame:
  - Stimulus: Rst low at Row_Idx = 50, asynchronous to Clk.
  - Required: outputs go to reset values immediately with no Done; a new Start then runs a clean frame with Out_Count = 9604.

Source files
------------

// File: rtl/conv_window_sequencer.sv
// Frame-level sequencer for the convolution datapath: accepts one raster frame,
// tracks column/row position and hands each completed KxK window to the MAC array.
module conv_window_sequencer #(
  parameter int unsigned IMG_WIDTH  = 100,
  parameter int unsigned IMG_HEIGHT = 100,
  parameter int unsigned KERNEL     = 3,
  parameter int unsigned CNT_WIDTH  = 14
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 Start,
  input  logic                 In_Valid,
  output logic                 In_Ready,
  input  logic                 Out_Ready,
  output logic                 Out_Valid,
  output logic                 Shift_En,
  output logic                 Row_Start,
  output logic [CNT_WIDTH-1:0] Col_Idx,
  output logic [CNT_WIDTH-1:0] Row_Idx,
  output logic [CNT_WIDTH-1:0] Out_Count,
  output logic                 Busy,
  output logic                 Done
);

  localparam logic [CNT_WIDTH-1:0] LP_W       = CNT_WIDTH'(IMG_WIDTH);
  localparam logic [CNT_WIDTH-1:0] LP_H       = CNT_WIDTH'(IMG_HEIGHT);
  localparam logic [CNT_WIDTH-1:0] LP_K       = CNT_WIDTH'(KERNEL);
  localparam logic [CNT_WIDTH-1:0] LP_ONE     = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] LP_CNT_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [CNT_WIDTH-1:0]  r_col;
  logic [CNT_WIDTH-1:0]  r_row;
  logic [CNT_WIDTH-1:0]  r_out_cnt;
  logic                  r_out_valid;

  logic                  w_in_ready;
  logic                  w_accept;
  logic                  w_new_row;
  logic [CNT_WIDTH-1:0]  w_col_nxt;
  logic [CNT_WIDTH-1:0]  w_row_nxt;
  logic                  w_complete;
  logic                  w_last;
  logic                  w_handoff;

  // Handshake and position arithmetic for the pixel offered this cycle.
  always_comb begin
    w_in_ready = (r_state == S_RUN) && (!r_out_valid || Out_Ready);
    w_accept   = In_Valid && w_in_ready;
    w_new_row  = (r_col == LP_W) || (r_col == '0);
    w_col_nxt  = w_new_row ? LP_ONE : r_col + LP_ONE;
    w_row_nxt  = w_new_row ? r_row + LP_ONE : r_row;
    w_complete = w_accept && (w_col_nxt >= LP_K) && (w_row_nxt >= LP_K);
    w_last     = w_accept && (w_col_nxt == LP_W) && (w_row_nxt == LP_H);
    w_handoff  = r_out_valid && Out_Ready;
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (Start)     w_state_nxt = S_RUN;
      S_RUN:   if (w_last)    w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_handoff) w_state_nxt = S_DONE;
      S_DONE:                 w_state_nxt = S_IDLE;
      default:                w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    In_Ready  = w_in_ready;
    Shift_En  = w_accept;
    Row_Start = w_accept && w_new_row;
    Busy      = (r_state != S_IDLE);
    Done      = (r_state == S_DONE);
    Out_Valid = r_out_valid;
    Col_Idx   = r_col;
    Row_Idx   = r_row;
    Out_Count = r_out_cnt;
  end

  // Position counters, output slot and handoff count; a new window refills the slot
  // in the same cycle the previous one is consumed.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_col       <= '0;
      r_row       <= '0;
      r_out_cnt   <= '0;
      r_out_valid <= 1'b0;
    end else begin
      if ((r_state == S_IDLE) && Start) begin
        r_col     <= '0;
        r_row     <= '0;
        r_out_cnt <= '0;
      end else begin
        if (w_accept) begin
          r_col <= w_col_nxt;
          r_row <= w_row_nxt;
        end
        if (w_handoff && (r_out_cnt != LP_CNT_MAX)) begin
          r_out_cnt <= r_out_cnt + LP_ONE;
        end
      end
      if (w_complete) begin
        r_out_valid <= 1'b1;
      end else if (w_handoff) begin
        r_out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_conv_window_sequencer.sv
// Randomised bench for conv_window_sequencer: a pixel-index reference model feeds a
// window scoreboard, and a negedge monitor compares every DUT output against it.
module tb_conv_window_sequencer;

  localparam int W         = 100;
  localparam int H         = 100;
  localparam int K         = 3;
  localparam int CW        = 14;
  localparam int WIN_TOTAL = (W - K + 1) * (H - K + 1);
  localparam int M_IDLE    = 0;
  localparam int M_RUN     = 1;
  localparam int M_DRAIN   = 2;
  localparam int M_DONE    = 3;

  logic          Clk;
  logic          Rst;
  logic          Start;
  logic          In_Valid;
  logic          In_Ready;
  logic          Out_Ready;
  logic          Out_Valid;
  logic          Shift_En;
  logic          Row_Start;
  logic [CW-1:0] Col_Idx;
  logic [CW-1:0] Row_Idx;
  logic [CW-1:0] Out_Count;
  logic          Busy;
  logic          Done;

  conv_window_sequencer #(
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H),
    .KERNEL    (K),
    .CNT_WIDTH (CW)
  ) dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .Start    (Start),
    .In_Valid (In_Valid),
    .In_Ready (In_Ready),
    .Out_Ready(Out_Ready),
    .Out_Valid(Out_Valid),
    .Shift_En (Shift_En),
    .Row_Start(Row_Start),
    .Col_Idx  (Col_Idx),
    .Row_Idx  (Row_Idx),
    .Out_Count(Out_Count),
    .Busy     (Busy),
    .Done     (Done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Reference model: frame progress kept as a count of accepted pixels.
  int m_state = M_IDLE;
  int m_pix   = 0;
  bit m_valid = 1'b0;
  int m_count = 0;
  int m_win   = 0;
  int sb_q[$];

  int n_checks = 0;
  int n_errors = 0;

  function automatic int col_of(input int pix);
    return (pix == 0) ? 0 : ((pix - 1) % W) + 1;
  endfunction

  function automatic int row_of(input int pix);
    return (pix == 0) ? 0 : ((pix - 1) / W) + 1;
  endfunction

  initial begin : model
    forever begin
      @(posedge Clk or negedge Rst);
      if (!Rst) begin
        m_state = M_IDLE;
        m_pix   = 0;
        m_valid = 1'b0;
        m_count = 0;
        m_win   = 0;
        sb_q.delete();
      end else begin
        case (m_state)
          M_IDLE: begin
            if (Start) begin
              m_state = M_RUN;
              m_pix   = 0;
              m_count = 0;
              m_win   = 0;
            end
          end
          M_RUN: begin
            bit rdy;
            bit acc;
            bit comp;
            rdy  = !m_valid || Out_Ready;
            acc  = In_Valid && rdy;
            comp = 1'b0;
            if (m_valid && Out_Ready) m_count++;
            if (acc) begin
              m_pix++;
              comp = (col_of(m_pix) >= K) && (row_of(m_pix) >= K);
              if (comp) begin
                sb_q.push_back(m_win);
                m_win++;
              end
              if (m_pix == W * H) m_state = M_DRAIN;
            end
            m_valid = comp || (m_valid && !Out_Ready);
          end
          M_DRAIN: begin
            if (m_valid && Out_Ready) begin
              m_count++;
              m_valid = 1'b0;
              m_state = M_DONE;
            end
          end
          default: m_state = M_IDLE;
        endcase
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      if (n_errors <= 20)
        $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: per-cycle comparisons plus scoreboard pops on each window handoff.
  int frame_shift = 0;
  int frame_rs    = 0;
  bit first_seen  = 1'b0;

  initial begin : monitor
    forever begin
      @(negedge Clk);
      if (!Rst) begin
        chk("rst_col_idx",   int'(Col_Idx),   0);
        chk("rst_row_idx",   int'(Row_Idx),   0);
        chk("rst_out_count", int'(Out_Count), 0);
        chk("rst_out_valid", int'(Out_Valid), 0);
        chk("rst_busy",      int'(Busy),      0);
        chk("rst_done",      int'(Done),      0);
        chk("rst_in_ready",  int'(In_Ready),  0);
        chk("rst_shift_en",  int'(Shift_En),  0);
        frame_shift = 0;
        frame_rs    = 0;
        first_seen  = 1'b0;
      end else begin
        bit exp_rdy;
        bit exp_sh;
        int exp_ord;
        exp_rdy = (m_state == M_RUN) && (!m_valid || Out_Ready);
        exp_sh  = In_Valid && exp_rdy;
        chk("in_ready",  int'(In_Ready),  int'(exp_rdy));
        chk("shift_en",  int'(Shift_En),  int'(exp_sh));
        chk("row_start", int'(Row_Start), int'(exp_sh && (col_of(m_pix) == W || m_pix == 0)));
        chk("col_idx",   int'(Col_Idx),   col_of(m_pix));
        chk("row_idx",   int'(Row_Idx),   row_of(m_pix));
        chk("out_valid", int'(Out_Valid), int'(m_valid));
        chk("out_count", int'(Out_Count), m_count);
        chk("busy",      int'(Busy),      int'(m_state != M_IDLE));
        chk("done",      int'(Done),      int'(m_state == M_DONE));
        if (Out_Valid && !first_seen) begin
          chk("first_window_accepts", frame_shift, (K - 1) * W + K);
          first_seen = 1'b1;
        end
        if (Out_Valid && Out_Ready) begin
          exp_ord = (sb_q.size() > 0) ? sb_q.pop_front() : -1;
          chk("sb_window_ordinal", int'(Out_Count), exp_ord);
        end
        if (Shift_En)  frame_shift++;
        if (Row_Start) frame_rs++;
        if (m_state == M_DONE) begin
          chk("frame_shift_total", frame_shift,      W * H);
          chk("frame_row_starts",  frame_rs,         H);
          chk("frame_out_count",   int'(Out_Count),  WIN_TOTAL);
          chk("sb_empty_at_done",  sb_q.size(),      0);
        end
        if (Start && m_state == M_IDLE) begin
          frame_shift = 0;
          frame_rs    = 0;
          first_seen  = 1'b0;
        end
      end
    end
  end

  task automatic start_frame();
    @(posedge Clk);
    #1 Start = 1'b1;
    @(posedge Clk);
    #1 Start = 1'b0;
  endtask

  // mode 0: no stalls; 1: random with stall, mid-run Start and drain hold; 2: abort at row 50
  task automatic run_frame(input int mode);
    int cyc        = 0;
    int stall      = 0;
    bit stall_done = 1'b0;
    int drain_hold = 0;
    while (m_state != M_IDLE) begin
      if (cyc > 40000) begin
        $display("FAIL frame_timeout: state %0d pixels %0d, expected frame end", m_state, m_pix);
        $fatal(1, "frame did not complete within cycle budget");
      end
      Start = 1'b0;
      if (mode == 0) begin
        In_Valid  = 1'b1;
        Out_Ready = 1'b1;
      end else begin
        In_Valid  = ($urandom_range(7) != 0);
        Out_Ready = ($urandom_range(3) != 0);
        if (mode == 1 && cyc == 600) Start = 1'b1;
        if (mode == 1 && !stall_done && stall == 0 && m_valid && cyc > 300) stall = 5;
        if (stall > 0) begin
          Out_Ready = 1'b0;
          stall--;
          if (stall == 0) stall_done = 1'b1;
        end
        if (mode == 1 && m_state == M_DRAIN) begin
          if (drain_hold < 4) begin
            Out_Ready = 1'b0;
            drain_hold++;
          end else begin
            Out_Ready = 1'b1;
          end
        end
        if (mode == 2 && row_of(m_pix) == 50) begin
          #2 Rst = 1'b0;
          repeat (2) @(posedge Clk);
          #3 Rst = 1'b1;
          return;
        end
      end
      cyc++;
      @(posedge Clk);
      #1;
    end
  endtask

  initial begin : driver
    Rst       = 1'b0;
    Start     = 1'b0;
    In_Valid  = 1'b0;
    Out_Ready = 1'b0;
    repeat (3) @(posedge Clk);
    #3 Rst = 1'b1;

    @(posedge Clk);
    #1 In_Valid = 1'b1;
    repeat (10) @(posedge Clk);
    #1 In_Valid = 1'b0;

    start_frame();
    run_frame(0);

    start_frame();
    run_frame(1);

    start_frame();
    run_frame(2);

    start_frame();
    run_frame(1);

    repeat (5) @(posedge Clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
